decimal_entry: RTL and testbench

DECIMAL_ENTRY -- requirements
Module: decimal_entry

---
 rtl/decimal_entry_pkg.sv | 51 +++++
 rtl/decimal_entry_bcd_mac10.sv | 14 +
 rtl/decimal_entry.sv | 105 ++++++++++
 tb/tb_decimal_entry.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decimal_entry_pkg.sv
// Shared state encoding, saturation limits and conversion helper for decimal_entry.
// Define DECIMAL_ENTRY_SIGN_EN for signed entry; otherwise the result is unsigned.
package decimal_entry_pkg;

    localparam int unsigned ACC_W   = 35;
    localparam logic [31:0] POS_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_MAX = 32'h8000_0000;
    localparam logic [31:0] UNS_MAX = 32'hFFFF_FFFF;

`ifdef DECIMAL_ENTRY_SIGN_EN
    localparam bit SIGN_EN = 1'b1;
`else
    localparam bit SIGN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ENTRY,
        CONV,
        DONE
    } state_t;

    typedef struct packed {
        logic        overflow;
        logic [31:0] value;
    } result_t;

    // Magnitude 2^31 with a minus sign is representable, so only larger magnitudes saturate.
    function automatic result_t convert(input logic [ACC_W-1:0] mag, input logic sign);
        result_t r;
        r.overflow = 1'b0;
        r.value    = mag[31:0];
        if (SIGN_EN && sign) begin
            if (mag > ACC_W'(NEG_MAX)) begin
                r.overflow = 1'b1;
                r.value    = NEG_MAX;
            end else begin
                r.value = -mag[31:0];
            end
        end else if (SIGN_EN) begin
            if (mag > ACC_W'(POS_MAX)) begin
                r.overflow = 1'b1;
                r.value    = POS_MAX;
            end
        end else if (mag > ACC_W'(UNS_MAX)) begin
            r.overflow = 1'b1;
            r.value    = UNS_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/decimal_entry_bcd_mac10.sv
// Combinational multiply-by-ten-and-add for decimal digit accumulation.
module bcd_mac10 #(
    parameter int unsigned W = 35
) (
    input  logic [W-1:0] acc,
    input  logic [3:0]   digit,
    output logic [W-1:0] result
);

    always_comb begin
        result = (acc << 3) + (acc << 1) + {{(W-4){1'b0}}, digit};
    end

endmodule

// File: rtl/decimal_entry.sv
// Keypad decimal entry: accumulates BCD digits and converts to a saturated 32-bit result.
// Signed entry (neg_key, negative saturation) is enabled by DECIMAL_ENTRY_SIGN_EN.
module decimal_entry
    import decimal_entry_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  digit,
    input  logic        digit_valid,
    output logic        digit_ready,
    input  logic        neg_key,
    input  logic        enter,
    input  logic        clear,
    output logic [31:0] value,
    output logic        value_valid,
    output logic        overflow,
    output logic        neg,
    output logic [3:0]  digit_count
);

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_mac;
    logic             neg_q;
    logic             accept;
    result_t          conv;

    bcd_mac10 #(.W(ACC_W)) u_mac (
        .acc    (acc),
        .digit  (digit),
        .result (acc_mac)
    );

    assign conv   = convert(acc, neg_q);
    assign accept = digit_valid && digit_ready && (digit <= 4'd9);
    assign neg    = neg_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ENTRY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        digit_ready = 1'b0;
        case (state)
            ENTRY: begin
                digit_ready = 32'(digit_count) < MAX_DIGITS;
                if (enter) state_next = CONV;
            end
            CONV:    state_next = DONE;
            DONE:    state_next = ENTRY;
            default: state_next = ENTRY;
        endcase
        if (clear) state_next = ENTRY;
    end

    // value_valid is registered on DONE exit, giving the two-cycle enter-to-valid latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc         <= '0;
            digit_count <= '0;
            neg_q       <= 1'b0;
            value       <= '0;
            overflow    <= 1'b0;
            value_valid <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            if (clear) begin
                acc         <= '0;
                digit_count <= '0;
                neg_q       <= 1'b0;
            end else begin
                case (state)
                    ENTRY: begin
                        if (accept) begin
                            acc         <= acc_mac;
                            digit_count <= digit_count + 4'd1;
                        end
                        if (SIGN_EN && neg_key) neg_q <= ~neg_q;
                    end
                    CONV: begin
                        value    <= conv.value;
                        overflow <= conv.overflow;
                        if (acc == '0) neg_q <= 1'b0;
                    end
                    DONE: begin
                        value_valid <= 1'b1;
                        acc         <= '0;
                        digit_count <= '0;
                        neg_q       <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decimal_entry.sv
// Scoreboard bench for decimal_entry; expectations follow DECIMAL_ENTRY_SIGN_EN if defined.
module tb_decimal_entry;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        digit_ready;
    logic        neg_key;
    logic        enter;
    logic        clear;
    logic [31:0] value;
    logic        value_valid;
    logic        overflow;
    logic        neg;
    logic [3:0]  digit_count;

`ifdef DECIMAL_ENTRY_SIGN_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    typedef struct {
        logic [31:0] value;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clock = ~clock;

    decimal_entry #(.MAX_DIGITS(10)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .neg_key     (neg_key),
        .enter       (enter),
        .clear       (clear),
        .value       (value),
        .value_valid (value_valid),
        .overflow    (overflow),
        .neg         (neg),
        .digit_count (digit_count)
    );

    // Reference conversion from an exact decimal magnitude and sign.
    function automatic exp_t model(input longint unsigned mag, input bit sgn);
        exp_t e;
        e.ovf = 1'b0;
        if (SIGNED_MODE && sgn) begin
            if (mag > 64'd2147483648) begin
                e.ovf = 1'b1;
                e.value = 32'h8000_0000;
            end else begin
                e.value = 32'(64'd0 - mag);
            end
        end else if (SIGNED_MODE) begin
            if (mag > 64'd2147483647) begin
                e.ovf = 1'b1;
                e.value = 32'h7FFF_FFFF;
            end else begin
                e.value = mag[31:0];
            end
        end else if (mag > 64'd4294967295) begin
            e.ovf = 1'b1;
            e.value = 32'hFFFF_FFFF;
        end else begin
            e.value = mag[31:0];
        end
        return e;
    endfunction

    always @(posedge clock) begin
        #1;
        if (value_valid === 1'b1) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_valid: value_valid=1 value=%h, required no pulse", value);
            end else begin
                mon_e = sb.pop_front();
                if (value !== mon_e.value) begin
                    mismatched++;
                    $display("FAIL result_value: got %h, required %h", value, mon_e.value);
                end
                compared++;
                if (overflow !== mon_e.ovf) begin
                    mismatched++;
                    $display("FAIL result_overflow: got %b, required %b", overflow, mon_e.ovf);
                end
            end
        end
    end

    task automatic send_digit(input logic [3:0] d);
        digit       = d;
        digit_valid = 1'b1;
        @(negedge clock);
        digit_valid = 1'b0;
    endtask

    task automatic pulse_neg();
        neg_key = 1'b1;
        @(negedge clock);
        neg_key = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    // Pulses enter and returns cycles until value_valid (10 on timeout).
    task automatic finish_entry(output int lat);
        enter = 1'b1;
        @(negedge clock);
        enter       = 1'b0;
        digit_valid = 1'b0;
        lat = 0;
        while (value_valid !== 1'b1 && lat < 10) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        compared++;
        if ({value, overflow, value_valid, neg, digit_count} !== 39'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: value=%h ovf=%b vv=%b neg=%b cnt=%0d, required all 0",
                     value, overflow, value_valid, neg, digit_count);
        end
        compared++;
        if (digit_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_ready: got %b, required 1", digit_ready);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int lat;
        sb.push_back('{32'h0000_04D2, 1'b0});
        send_digit(4'd1); send_digit(4'd2); send_digit(4'd3); send_digit(4'd4);
        compared++;
        if (digit_count !== 4'd4) begin
            mismatched++;
            $display("FAIL basic_count: got %0d, required 4", digit_count);
        end
        finish_entry(lat);
        compared++;
        if (lat !== 2) begin
            mismatched++;
            $display("FAIL basic_latency: got %0d cycles, required 2", lat);
        end
        @(negedge clock);
        compared++;
        if (value_valid !== 1'b0 || digit_count !== 4'd0) begin
            mismatched++;
            $display("FAIL basic_pulse_end: vv=%b cnt=%0d, required vv=0 cnt=0", value_valid, digit_count);
        end
    endtask

    task automatic test_negative();
        int d[10] = '{2, 1, 4, 7, 4, 8, 3, 6, 4, 8};
        int lat;
        for (int pass = 0; pass < 2; pass++) begin
            longint unsigned mag = 0;
            if (pass == 1) d[9] = 9;
            pulse_neg();
            compared++;
            if (neg !== SIGNED_MODE) begin
                mismatched++;
                $display("FAIL neg_flag: got %b, required %b", neg, SIGNED_MODE);
            end
            for (int i = 0; i < 10; i++) begin
                send_digit(4'(d[i]));
                mag = mag * 10 + longint'(d[i]);
            end
            sb.push_back(model(mag, 1'b1));
            finish_entry(lat);
            compared++;
            if (lat !== 2) begin
                mismatched++;
                $display("FAIL neg_latency: got %0d cycles, required 2", lat);
            end
            @(negedge clock);
            compared++;
            if (neg !== 1'b0) begin
                mismatched++;
                $display("FAIL neg_cleared: got %b, required 0", neg);
            end
        end
        pulse_neg();
        send_digit(4'd5);
        sb.push_back(model(64'd5, 1'b1));
        finish_entry(lat);
        @(negedge clock);
        pulse_neg();
        sb.push_back(model(64'd0, 1'b1));
        finish_entry(lat);
        compared++;
        if (neg !== 1'b0 || value !== 32'd0) begin
            mismatched++;
            $display("FAIL neg_zero: neg=%b value=%h, required neg=0 value=0", neg, value);
        end
        @(negedge clock);
    endtask

    task automatic test_saturate();
        int lat;
        for (int i = 0; i < 10; i++) send_digit(4'd9);
        compared++;
        if (digit_ready !== 1'b0 || digit_count !== 4'd10) begin
            mismatched++;
            $display("FAIL sat_full: ready=%b cnt=%0d, required ready=0 cnt=10", digit_ready, digit_count);
        end
        send_digit(4'd9);
        compared++;
        if (digit_count !== 4'd10) begin
            mismatched++;
            $display("FAIL sat_11th: cnt=%0d, required 10", digit_count);
        end
        sb.push_back(model(64'd9999999999, 1'b0));
        finish_entry(lat);
        compared++;
        if (lat !== 2) begin
            mismatched++;
            $display("FAIL sat_latency: got %0d cycles, required 2", lat);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_in_conv();
        send_digit(4'd8); send_digit(4'd8);
        enter = 1'b1;
        @(negedge clock);
        enter   = 1'b0;
        reset_n = 1'b0;
        #1;
        compared++;
        if ({value, overflow, value_valid, neg, digit_count} !== 39'd0) begin
            mismatched++;
            $display("FAIL reset_conv: value=%h ovf=%b vv=%b neg=%b cnt=%0d, required all 0",
                     value, overflow, value_valid, neg, digit_count);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        compared++;
        if (value !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_conv_after: value=%h, required 0", value);
        end
    endtask

    task automatic test_clear();
        int lat;
        send_digit(4'd5); send_digit(4'd6);
        pulse_clear();
        compared++;
        if (digit_count !== 4'd0) begin
            mismatched++;
            $display("FAIL clear_count: got %0d, required 0", digit_count);
        end
        repeat (4) @(negedge clock);
        sb.push_back('{32'h0000_0007, 1'b0});
        send_digit(4'd7);
        finish_entry(lat);
        compared++;
        if (lat !== 2) begin
            mismatched++;
            $display("FAIL clear_latency: got %0d cycles, required 2", lat);
        end
        @(negedge clock);
    endtask

    task automatic test_same_cycle();
        int lat;
        sb.push_back('{32'h0000_0003, 1'b0});
        digit       = 4'd3;
        digit_valid = 1'b1;
        finish_entry(lat);
        compared++;
        if (lat !== 2) begin
            mismatched++;
            $display("FAIL same_latency: got %0d cycles, required 2", lat);
        end
        @(negedge clock);
        send_digit(4'hA);
        compared++;
        if (digit_count !== 4'd0 || digit_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bad_digit: cnt=%0d ready=%b, required cnt=0 ready=1", digit_count, digit_ready);
        end
        sb.push_back('{32'h0000_0000, 1'b0});
        finish_entry(lat);
        @(negedge clock);
    endtask

    initial begin
        digit       = 4'd0;
        digit_valid = 1'b0;
        neg_key     = 1'b0;
        enter       = 1'b0;
        clear       = 1'b0;
        reset_n     = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_negative();
        test_saturate();
        test_reset_in_conv();
        test_clear();
        test_same_cycle();
        repeat (3) @(negedge clock);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL pending_results: %0d outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
